// File: rtl/sel_btn_pkg.sv
// Shared constants and helpers for the button/LED channel selector.
package sel_btn_pkg;

    localparam logic MODE_GATE   = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    // Counter only ever reaches DEB_CYCLES-1, so this width never wraps.
    function automatic int deb_cnt_w(input int deb_cycles);
        return (deb_cycles < 1) ? 1 : $clog2(deb_cycles + 1);
    endfunction

endpackage

// File: rtl/sel_btn_latch_if.sv
// Board-side bundle: slide switches, clear, raw buttons in; LED drive out.
interface sel_btn_latch_if #(
    parameter int N_CH = 4
);
    localparam int SEL_W = $clog2(N_CH);

    logic [SEL_W-1:0] sw;
    logic             mode;
    logic             clr;
    logic [N_CH-1:0]  btn;
    logic [N_CH-1:0]  led;

    modport master (output sw, mode, clr, btn, input led);
    modport slave  (input sw, mode, clr, btn, output led);

endinterface

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, stable-count debounce, rising-edge detect.
module btn_debounce
    import sel_btn_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb,
    output logic rise
);

    localparam int CW = deb_cnt_w(DEB_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          deb_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            deb_d <= deb;
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                // Input has differed for DEB_CYCLES consecutive cycles: accept it.
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = deb & ~deb_d;

endmodule

// File: rtl/sel_btn_latch.sv
// Channel selector: switches pick one channel, its debounced button gates or toggles its LED.
module sel_btn_latch
    import sel_btn_pkg::*;
#(
    parameter  int N_CH       = 4,
    parameter  int DEB_CYCLES = 4,
    localparam int SEL_W      = $clog2(N_CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    sel_btn_latch_if.slave bus
);

    logic [1:0][SEL_W-1:0] sw_sync;
    logic [1:0]            mode_sync;
    logic [N_CH-1:0]       deb;
    logic [N_CH-1:0]       rise;
    logic [N_CH-1:0]       sel;
    logic [N_CH-1:0]       lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync   <= '0;
            mode_sync <= '0;
        end else begin
            sw_sync   <= {sw_sync[0], bus.sw};
            mode_sync <= {mode_sync[0], bus.mode};
        end
    end

    // Out-of-range select codes (non-power-of-two N_CH) match no channel.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (bus.btn[i]),
            .deb  (deb[i]),
            .rise (rise[i])
        );
        assign sel[i] = (sw_sync[1] == SEL_W'(i));
    end

    // Latches run in both modes; clear beats a same-cycle press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       lat <= '0;
        else if (bus.clr) lat <= '0;
        else              lat <= lat ^ (rise & sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           bus.led <= '0;
        else if (mode_sync[1] == MODE_TOGGLE) bus.led <= lat;
        else                                  bus.led <= deb & sel;
    end

endmodule

// File: tb/tb_sel_btn_latch.sv
// Directed + random bench for sel_btn_latch with a history-window reference model.
module tb_sel_btn_latch;

    localparam int N    = 4;
    localparam int DEB  = 4;
    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sel_btn_latch_if #(.N_CH(N)) ifa ();
    sel_btn_latch_if #(.N_CH(3)) ifb ();

    sel_btn_latch #(.N_CH(N), .DEB_CYCLES(DEB)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    sel_btn_latch #(.N_CH(3), .DEB_CYCLES(DEB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int vectors = 0;
    int miscompares = 0;

    // Per-edge history; entries before 'base' (last reset release) read as 0.
    logic [N-1:0] raw_h [MAXC];
    logic [N-1:0] deb_h [MAXC];
    logic [N-1:0] lat_h [MAXC];
    logic [1:0]   sw_h  [MAXC];
    logic         mode_h[MAXC];
    logic         clr_h [MAXC];
    int cyc  = 0;
    int base = 1;

    function automatic logic [N-1:0] raw_at(int n);  return (n < base) ? '0 : raw_h[n];  endfunction
    function automatic logic [N-1:0] deb_at(int n);  return (n < base) ? '0 : deb_h[n];  endfunction
    function automatic logic [N-1:0] lat_at(int n);  return (n < base) ? '0 : lat_h[n];  endfunction
    function automatic logic [1:0]   sw_at(int n);   return (n < base) ? '0 : sw_h[n];   endfunction
    function automatic logic         mode_at(int n); return (n < base) ? 1'b0 : mode_h[n]; endfunction

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: led=%b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkb(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: led=%b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one edge and compare DUT A to the model. A button is accepted once the
    // synchronised input has disagreed with the stable state for DEB straight edges.
    task automatic step();
        int n;
        logic [N-1:0] d, sel, rise, l, exp, r;
        logic [1:0] s;
        bit flip;
        n = cyc + 1;
        raw_h[n]  = ifa.btn;
        sw_h[n]   = ifa.sw;
        mode_h[n] = ifa.mode;
        clr_h[n]  = ifa.clr;
        @(posedge clk);
        d = deb_at(n - 1);
        for (int i = 0; i < N; i++) begin
            flip = 1'b1;
            for (int m = n - DEB + 1; m <= n; m++) begin
                r = raw_at(m - 2);
                if (r[i] == d[i]) flip = 1'b0;
            end
            if (flip) d[i] = ~d[i];
        end
        deb_h[n] = d;
        s = sw_at(n - 2);
        sel = '0;
        sel[s] = 1'b1;
        rise = deb_at(n - 1) & ~deb_at(n - 2);
        l = clr_h[n] ? '0 : (lat_at(n - 1) ^ (rise & sel));
        lat_h[n] = l;
        exp = mode_at(n - 2) ? lat_at(n - 1) : (deb_at(n - 1) & sel);
        cyc = n;
        #1;
        check("model", ifa.led, exp);
    endtask

    task automatic press(input int ch, input int len);
        ifa.btn[ch] = 1'b1;
        repeat (len) step();
        ifa.btn[ch] = 1'b0;
        repeat (len) step();
    endtask

    initial begin
        ifa.btn = '1; ifa.sw = 2'd2; ifa.mode = 1'b0; ifa.clr = 1'b0;
        ifb.btn = '0; ifb.sw = 2'd0; ifb.mode = 1'b0; ifb.clr = 1'b0;

        // Reset held with all buttons pressed: LEDs dark, then ch2 after debounce.
        repeat (3) begin @(posedge clk); #1 check("reset_hold", ifa.led, '0); end
        @(negedge clk); rst_n = 1'b1; base = cyc + 1;
        repeat (DEB + 2) step();
        check("rst_deb_pending", ifa.led, 4'b0000);
        step();
        check("rst_deb_done", ifa.led, 4'b0100);

        // Gate mode latency on channel 1.
        ifa.btn = '0; ifa.sw = 2'd1;
        repeat (12) step();
        ifa.btn = 4'b0010;
        repeat (DEB + 2) step();
        check("gate_rise_early", ifa.led, 4'b0000);
        step();
        check("gate_rise", ifa.led, 4'b0010);
        ifa.btn = '0;
        repeat (DEB + 2) step();
        check("gate_fall_early", ifa.led, 4'b0010);
        step();
        check("gate_fall", ifa.led, 4'b0000);

        // Debounce: short glitch ignored, longer pulse accepted.
        ifa.sw = 2'd3;
        repeat (4) step();
        ifa.btn[3] = 1'b1;
        repeat (DEB - 1) step();
        ifa.btn[3] = 1'b0;
        repeat (12) step();
        check("glitch", ifa.led, 4'b0000);
        ifa.btn[3] = 1'b1;
        repeat (DEB + 2) step();
        ifa.btn[3] = 1'b0;
        step();
        check("long_pulse", ifa.led, 4'b1000);
        repeat (12) step();

        // Toggle mode on channel 0, starting from cleared latches.
        ifa.mode = 1'b1; ifa.sw = 2'd0; ifa.clr = 1'b1;
        step();
        ifa.clr = 1'b0;
        repeat (6) step();
        press(0, DEB + 4);
        check("toggle_on", ifa.led, 4'b0001);
        press(0, DEB + 4);
        check("toggle_off", ifa.led, 4'b0000);
        press(0, DEB + 4);
        press(2, DEB + 4);
        check("unselected_press", ifa.led, 4'b0001);
        ifa.sw = 2'd2;
        repeat (6) step();
        check("latch_retained", ifa.led, 4'b0001);

        // Clear coinciding with a rise on selected channel 1.
        ifa.clr = 1'b1; step(); ifa.clr = 1'b0;
        ifa.sw = 2'd1; repeat (4) step();
        press(1, DEB + 4);
        ifa.sw = 2'd3; repeat (4) step();
        press(3, DEB + 4);
        check("lat_1010", ifa.led, 4'b1010);
        ifa.sw = 2'd1; repeat (4) step();
        ifa.btn = 4'b0010;
        repeat (DEB + 2) step();
        ifa.clr = 1'b1;
        step();
        ifa.clr = 1'b0;
        step();
        check("clr_priority", ifa.led, 4'b0000);
        ifa.btn = '0;
        repeat (DEB + 6) step();
        check("clr_priority_hold", ifa.led, 4'b0000);

        // Three-channel instance: select code 3 addresses nothing.
        ifb.sw = 2'd3; ifb.btn = 3'b111; ifb.mode = 1'b0;
        repeat (15) begin step(); checkb("oor_gate", ifb.led, 3'b000); end
        ifb.mode = 1'b1;
        repeat (10) begin step(); checkb("oor_toggle", ifb.led, 3'b000); end
        ifb.sw = 2'd1; ifb.mode = 1'b0;
        repeat (4) step();
        checkb("inrange_gate", ifb.led, 3'b010);
        ifb.mode = 1'b1;
        repeat (5) step();
        checkb("inrange_toggle", ifb.led, 3'b000);

        // Random traffic.
        repeat (1500) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 15) ifa.btn[$urandom_range(0, N - 1)] ^= 1'b1;
            else if (r < 18) ifa.sw = 2'($urandom_range(0, 3));
            else if (r == 18) ifa.mode = ~ifa.mode;
            ifa.clr = (r == 19);
            step();
        end

        // Asynchronous reset mid-run.
        rst_n = 1'b0;
        #1 check("async_reset", ifa.led, '0);
        checkb("async_reset_b", ifb.led, 3'b000);
        repeat (2) begin @(posedge clk); #1 check("reset_mid", ifa.led, '0); end
        @(negedge clk); rst_n = 1'b1; base = cyc + 1;

        repeat (800) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 15) ifa.btn[$urandom_range(0, N - 1)] ^= 1'b1;
            else if (r < 18) ifa.sw = 2'($urandom_range(0, 3));
            else if (r == 18) ifa.mode = ~ifa.mode;
            ifa.clr = (r == 19);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sel_btn_latch.md
# sel_btn_latch

Parametrised channel selector driving the board LEDs from push buttons, successor to the fixed 4-channel combinational switch/button gate. Slide switches select one of N_CH channels; each button is synchronised and debounced, and only the selected channel's button affects its LED. Two modes: gate mode, where the LED follows the held button, and toggle mode, where each debounced press flips a per-channel latch that holds when deselected. Sits between the board I/O pins and the LED outputs.

## Interface
- N_CH, 4, number of button/LED channels (2..16)
- DEB_CYCLES, 4, consecutive stable cycles required to accept a button change (>= 1)
- SEL_W, $clog2(N_CH), derived width of the select input; not overridden
- clk  input  1  system clock; one clock domain for the whole block
- rst_n  input  1  asynchronous, active-low reset
- sw  input  SEL_W  channel select, asynchronous, from slide switches
- mode  input  1  0 = gate, 1 = toggle; asynchronous, from slide switch
- clr  input  1  synchronous clear of all toggle latches, active-high, already synchronous
- btn  input  N_CH  raw buttons, asynchronous, active-high
- led  output  N_CH  LED drive, registered

## Operation
- Synchronisers: sw, mode and btn each pass through 2 flops; all reset to 0.
- Debounce, per channel: stable state deb[i] (reset 0) and counter cnt[i], width $clog2(DEB_CYCLES+1) (reset 0).
  - When the sync output equals deb[i], cnt[i] is set to 0.
  - Otherwise cnt[i] increments. When cnt[i] equals DEB_CYCLES-1 and the input still differs, deb[i] flips and cnt[i] is set to 0.
  - The counter never wraps.
- Select decode: sel[i] = 1 only for i == synced sw. If synced sw >= N_CH (non-power-of-two N_CH), no channel is selected.
- Press event: rise[i] = deb[i] rising edge, detected against a 1-cycle delayed copy of deb[i].
- Toggle latches lat[i] (reset 0):
  - If clr is 1, all lat are cleared. This has priority over a press in the same cycle.
  - Otherwise, lat[i] inverts on rise[i] & sel[i].
  - Latches update in both modes and hold while their channel is deselected.
- Output register (reset 0):
  - mode 0: led[i] <= deb[i] & sel[i].
  - mode 1: led[i] <= lat[i].
- Changing sw while a button is held:
  - In gate mode the LED moves to the new channel only if that channel's button is held.
  - In toggle mode no toggle occurs, because there is no new rising edge.
- Reset asserted mid-operation: all state, including latches, returns to 0 immediately and asynchronously.

## Timing
- Button to deb: a btn level held stable from edge k updates deb at edge k+2+DEB_CYCLES.
- deb to led:
  - gate mode: 1 further edge.
  - toggle mode: 2 further edges (edge detect, then latch, then output register; the latch and led registers are pipelined, so total is deb + 2).
- sw and mode changes reach led 3 edges after a stable change (2 sync + 1 output).
- Glitches at the sync output shorter than DEB_CYCLES cycles never change deb.
- After rst_n rises, led stays 0 until a debounced press arrives.

## Structure
- Package sel_btn_pkg: mode constants MODE_GATE = 1'b0 and MODE_TOGGLE = 1'b1, plus a helper function for the counter width.
- Sub-module btn_debounce, instantiated N_CH times in a generate loop.
  - Parameter: DEB_CYCLES.
  - Ports: clk, rst_n, raw in, deb out, rise out.
  - Contains the 2-flop synchroniser, the counter and the edge detect.
- Top level contains the sw/mode synchronisers, select decode, latch array and output register.

## Test plan
- Reset: hold rst_n = 0 with btn = 4'b1111 and sw = 2 -> led = 0 throughout. Release -> led = 0 until debounce completes, then led = 4'b0100 in mode 0.
- Gate mode: sw = 1, raise btn[1] -> led = 4'b0010 exactly 2+DEB_CYCLES+1 edges later. Drop btn[1] -> led returns to 0 after the same delay.
- Debounce: pulse btn[3] high for DEB_CYCLES-1 cycles with sw = 3 -> led stays 0. Pulse for DEB_CYCLES+2 cycles -> led[3] goes to 1.
- Toggle mode: mode = 1, sw = 0, two clean presses of btn[0] -> led[0] goes 1 then 0. Press btn[2] with sw = 0 -> no change. Switch to sw = 2 -> led[0] latch state is retained.
- Clear priority: in mode 1 with lat = 4'b1010, assert clr in the same cycle as a rise on selected channel 1 -> led = 4'b0000.
- Out-of-range select: N_CH = 3, SEL_W = 2, sw = 3, press all buttons -> led = 0 in both modes.
